// File: rtl/mcpu_alu_sequencer.sv
// mcpu_alu_sequencer: instruction sequencer and register file in front of a combinational ALU.
// Runs IDLE -> DECODE -> EXEC -> WB for ALU ops and IDLE -> WB for load-immediate.
module mcpu_alu_sequencer #(
   parameter int CMD_SIZE  = 2,
   parameter int WORD_SIZE = 2,
   parameter int REG_ADDR  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic                 instr_mode,
   input  logic [CMD_SIZE-1:0]  instr_op,
   input  logic [REG_ADDR-1:0]  instr_rd,
   input  logic [REG_ADDR-1:0]  instr_rs1,
   input  logic [REG_ADDR-1:0]  instr_rs2,
   input  logic [WORD_SIZE-1:0] instr_imm,
   output logic [CMD_SIZE-1:0]  alu_opcode,
   output logic [WORD_SIZE-1:0] alu_r1,
   output logic [WORD_SIZE-1:0] alu_r2,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic                 alu_overflow,
   output logic                 done,
   output logic                 ovf_sticky,
   input  logic                 ovf_clear,
   input  logic [REG_ADDR-1:0]  dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data
);
   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
   state_t               state;
   logic                 mode;
   logic [CMD_SIZE-1:0]  op;
   logic [REG_ADDR-1:0]  rd, rs1, rs2;
   logic [WORD_SIZE-1:0] imm, result;
   logic                 ovf_cap;
   logic [WORD_SIZE-1:0] regs [2**REG_ADDR];

   assign instr_ready = (state == IDLE);
   assign dbg_data    = regs[dbg_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode       <= 1'b0;
         op         <= '0;
         rd         <= '0;
         rs1        <= '0;
         rs2        <= '0;
         imm        <= '0;
         result     <= '0;
         ovf_cap    <= 1'b0;
         alu_opcode <= '0;
         alu_r1     <= '0;
         alu_r2     <= '0;
         done       <= 1'b0;
         ovf_sticky <= 1'b0;
         for (int i = 0; i < 2**REG_ADDR; i++) regs[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (instr_valid) begin
               mode  <= instr_mode;
               op    <= instr_op;
               rd    <= instr_rd;
               rs1   <= instr_rs1;
               rs2   <= instr_rs2;
               imm   <= instr_imm;
               state <= instr_mode ? WB : DECODE;
               done  <= instr_mode;
            end
            DECODE: begin
               alu_opcode <= op;
               alu_r1     <= regs[rs1];
               alu_r2     <= regs[rs2];
               state      <= EXEC;
            end
            EXEC: begin
               result  <= alu_out;
               ovf_cap <= alu_overflow;
               state   <= WB;
               done    <= 1'b1;
            end
            WB: begin
               regs[rd] <= mode ? imm : result;
               if (mode) ovf_cap <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A set on the write-back edge takes priority over a simultaneous clear
         if (state == WB && !mode && ovf_cap) ovf_sticky <= 1'b1;
         else if (ovf_clear) ovf_sticky <= 1'b0;
      end
   end
endmodule

// File: doc/mcpu_alu_sequencer.md
# mcpu_alu_sequencer

Upstream control stage for the MCPU ALU. It accepts one instruction at a time over a valid/ready handshake and holds a small register file. It reads source operands, drives the combinational ALU's opcode and operand inputs from registers, captures the ALU result and overflow, and writes the result back. It also supports a load-immediate instruction so the register file can be seeded without the ALU.

## Interface
Parameters:
- CMD_SIZE, 2, ALU opcode width; matches the ALU parameter.
- WORD_SIZE, 2, data word width; matches the ALU parameter.
- REG_ADDR, 2, register address width; register file holds 2**REG_ADDR words.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept; equals (state == IDLE).
- instr_mode  in  1  0 = ALU op, 1 = load immediate.
- instr_op  in  CMD_SIZE  ALU opcode; ignored when mode = 1.
- instr_rd  in  REG_ADDR  destination register.
- instr_rs1, instr_rs2  in  REG_ADDR each  source registers; ignored when mode = 1.
- instr_imm  in  WORD_SIZE  immediate; ignored when mode = 0.
- alu_opcode  out  CMD_SIZE  registered, to ALU opcode.
- alu_r1, alu_r2  out  WORD_SIZE each  registered, to ALU operands.
- alu_out  in  WORD_SIZE  ALU result, combinational from the alu_* outputs.
- alu_overflow  in  1  ALU OVERFLOW.
- done  out  1  one-cycle pulse in the WB state.
- ovf_sticky  out  1  set by any ALU op with overflow; cleared by ovf_clear.
- ovf_clear  in  1  synchronous clear of ovf_sticky.
- dbg_addr  in  REG_ADDR  debug read address.
- dbg_data  out  WORD_SIZE  combinational read of the register file at dbg_addr.

## Operation
- States and transitions:
  - IDLE -> DECODE on handshake with mode = 0.
  - IDLE -> WB on handshake with mode = 1.
  - DECODE -> EXEC unconditionally.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- Handshake: an instruction is accepted on a rising edge where instr_valid && instr_ready.
  - All instr_* fields are latched at acceptance.
  - Later changes to the inputs have no effect.
  - instr_valid is ignored outside IDLE.
- DECODE edge: alu_opcode <= op, alu_r1 <= reg[rs1], alu_r2 <= reg[rs2].
  - rs1 == rs2 is legal; both operands receive the same value.
- EXEC edge: result <= alu_out and ovf_cap <= alu_overflow.
- WB edge, ALU op: reg[rd] <= result.
- WB edge, load immediate: reg[rd] <= imm and ovf_cap <= 0.
- ovf_sticky update on the WB edge of an ALU op with ovf_cap = 1: set.
  - ovf_clear in the same cycle: set wins.
  - ovf_clear in any other cycle: clears on that edge.
- alu_* outputs hold their last values outside DECODE updates; load immediate does not change them.
- All registers are writable, including register 0. Writes are WORD_SIZE wide with no extension or truncation logic.
- There is no internal bypass. A following instruction reads the written value because WB completes before the next acceptance.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - State = IDLE, so instr_ready = 1.
  - done = 0, ovf_sticky = 0.
  - alu_opcode, alu_r1, alu_r2 = 0.
  - All registers, result and ovf_cap = 0.
- ALU op accepted at edge T:
  - DECODE during T..T+1.
  - alu_* outputs valid from edge T+1.
  - EXEC during T+1..T+2; the sample is taken at T+2.
  - WB during T+2..T+3; done is high for exactly this cycle.
  - Register written at T+3; instr_ready is high again after T+3.
  - Throughput is one ALU op per 4 cycles.
- Load immediate accepted at edge T:
  - WB during T..T+1 with done high.
  - Register written at T+1; 2-cycle throughput.
- Reset asserted mid-instruction: the instruction is abandoned, no write occurs, and all state returns to reset values immediately.
- The ALU is combinational and must settle within one cycle; alu_out is sampled only at the EXEC edge.

## Test plan
- Reset: assert rst_n = 0 mid-EXEC -> instr_ready = 1, done = 0, ovf_sticky = 0, alu_r1 = alu_r2 = 0, and dbg_data = 0 for all addresses.
- Load immediates: r1 = 2'b11, r2 = 2'b01 -> done pulses one cycle after each acceptance, and dbg_data reads 3 and 1.
- ALU op:
  - Stimulus: op = 2'b10, rs1 = 1, rs2 = 2, rd = 3; the ALU stub returns alu_out = 2'b10 with overflow 0.
  - Response: alu_opcode = 2'b10, alu_r1 = 3, alu_r2 = 1 from edge T+1; done at T+2..T+3; r3 = 2 after T+3; ovf_sticky stays 0.
- Overflow: same op with the stub returning overflow 1 and ovf_clear = 1 on the WB cycle -> ovf_sticky = 1 (set wins). ovf_clear one cycle later -> 0.
- Back-to-back dependency:
  - Stimulus: instr_valid held high with two ALU ops, the second reading rd of the first (rs1 = 3).
  - Response: the second is accepted exactly 4 cycles after the first, and its alu_r1 equals the first op's result.
- Handshake robustness: toggle instr_* fields and instr_valid during DECODE/EXEC -> the in-flight operation is unchanged and no extra acceptance occurs.
